// File: rtl/digit_datapath_if.sv
// digit_datapath_if: strobes, external data and status of the digit datapath
interface digit_datapath_if #(
   parameter int WIDTH = 6
);
   logic             eA, eR, ext_en, lA, lB, lR, clr_err;
   logic [WIDTH-1:0] din, bus, a_q, b_q, r_q;
   logic             carry, zero, bus_err;
   modport master (
      output eA, eR, ext_en, din, lA, lB, lR, clr_err,
      input  bus, a_q, b_q, r_q, carry, zero, bus_err
   );
   modport slave (
      input  eA, eR, ext_en, din, lA, lB, lR, clr_err,
      output bus, a_q, b_q, r_q, carry, zero, bus_err
   );
endinterface

// File: rtl/digit_datapath.sv
// digit_datapath: shared-bus A/B/R registers, modulo adder, bus keeper and sticky contention flag
module digit_datapath #(
   parameter int WIDTH   = 6,
   parameter int MODULUS = 60
) (
   input logic             clk,
   input logic             rst_n,
   digit_datapath_if.slave io
);
   localparam int               W1  = WIDTH + 1;
   localparam logic [WIDTH:0]   MOD = W1'(MODULUS);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, keep_q, keep_d, bus, clamp;
   logic [WIDTH:0]   sum;
   logic             carry_q, carry_d, err_q, err_d, any, cont, wrap;
   always_comb begin
      bus     = io.eR ? r_q : io.eA ? a_q : io.ext_en ? io.din : keep_q;
      any     = io.eA | io.eR | io.ext_en;
      cont    = (io.eA & io.eR) | (io.eA & io.ext_en) | (io.eR & io.ext_en);
      clamp   = ({1'b0, bus} >= MOD) ? MAX : bus;
      sum     = {1'b0, a_q} + {1'b0, b_q};
      wrap    = sum >= MOD;
      keep_d  = any ? bus : keep_q;
      a_d     = io.lA ? clamp : a_q;
      b_d     = io.lB ? clamp : b_q;
      r_d     = !io.lR ? r_q : wrap ? WIDTH'(sum - MOD) : WIDTH'(sum);
      carry_d = io.lR ? wrap : carry_q;
      err_d   = cont ? 1'b1 : io.clr_err ? 1'b0 : err_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         keep_q  <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         keep_q  <= keep_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end
   assign io.bus     = bus;
   assign io.a_q     = a_q;
   assign io.b_q     = b_q;
   assign io.r_q     = r_q;
   assign io.carry   = carry_q;
   assign io.zero    = r_q == '0;
   assign io.bus_err = err_q;
endmodule

// File: tb/tb_digit_datapath.sv
// tb_digit_datapath: integer reference model checked every cycle plus directed literal checks
module tb_digit_datapath;
   localparam int W = 6;
   localparam int M = 60;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;
   int m_a, m_b, m_r, m_k, m_c, m_e;
   digit_datapath_if #(.WIDTH(W)) io ();
   digit_datapath #(.WIDTH(W), .MODULUS(M)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int exp_bus();
      return io.eR ? m_r : io.eA ? m_a : io.ext_en ? int'(io.din) : m_k;
   endfunction
   always @(negedge rst_n) begin
      m_a = 0; m_b = 0; m_r = 0; m_k = 0; m_c = 0; m_e = 0;
   end
   always @(posedge clk) begin
      if (rst_n) begin
         int b, n, cl;
         b  = exp_bus();
         n  = int'(io.eA) + int'(io.eR) + int'(io.ext_en);
         cl = (b >= M) ? M - 1 : b;
         if (n > 0) m_k = b;
         if (io.lR) begin
            m_c = (m_a + m_b >= M) ? 1 : 0;
            m_r = (m_a + m_b) % M;
         end
         if (io.lA) m_a = cl;
         if (io.lB) m_b = cl;
         if (n >= 2) m_e = 1;
         else if (io.clr_err) m_e = 0;
      end
   end
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_bus", int'(io.bus), exp_bus());
         chk("model_a", int'(io.a_q), m_a);
         chk("model_b", int'(io.b_q), m_b);
         chk("model_r", int'(io.r_q), m_r);
         chk("model_carry", int'(io.carry), m_c);
         chk("model_zero", int'(io.zero), (m_r == 0) ? 1 : 0);
         chk("model_err", int'(io.bus_err), m_e);
      end
   end
   task automatic step(input bit ea, input bit er, input bit ext, input int d,
                       input bit la, input bit lb, input bit lr, input bit clr);
      @(posedge clk);
      #2;
      io.eA = ea; io.eR = er; io.ext_en = ext; io.din = W'(d);
      io.lA = la; io.lB = lb; io.lR = lr; io.clr_err = clr;
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      io.eA = 0; io.eR = 0; io.ext_en = 0; io.din = '0;
      io.lA = 0; io.lB = 0; io.lR = 0; io.clr_err = 0;
      #12 rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (3) idle();
      chk("rst_bus", int'(io.bus), 0);
      chk("rst_a", int'(io.a_q), 0);
      chk("rst_b", int'(io.b_q), 0);
      chk("rst_r", int'(io.r_q), 0);
      chk("rst_zero", int'(io.zero), 1);
      chk("rst_carry", int'(io.carry), 0);
      chk("rst_err", int'(io.bus_err), 0);
      step(0, 0, 1, 25, 1, 0, 0, 0);
      step(0, 0, 1, 40, 0, 1, 0, 0);
      chk("add_a", int'(io.a_q), 25);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      chk("add_b", int'(io.b_q), 40);
      idle();
      chk("add_r", int'(io.r_q), 5);
      chk("add_carry", int'(io.carry), 1);
      chk("add_zero", int'(io.zero), 0);
      step(0, 0, 1, 63, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 1, 0, 0);
      chk("clamp_a", int'(io.a_q), 59);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      chk("wrap_r", int'(io.r_q), 0);
      chk("wrap_carry", int'(io.carry), 1);
      chk("wrap_zero", int'(io.zero), 1);
      step(0, 0, 1, 12, 1, 0, 0, 0);
      step(1, 0, 1, 7, 0, 1, 0, 0);
      @(negedge clk);
      chk("cont_bus", int'(io.bus), 12);
      idle();
      chk("cont_b", int'(io.b_q), 12);
      chk("cont_err", int'(io.bus_err), 1);
      idle();
      chk("err_sticky", int'(io.bus_err), 1);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      idle();
      chk("err_set_wins", int'(io.bus_err), 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      chk("err_clr", int'(io.bus_err), 0);
      step(0, 0, 1, 20, 1, 0, 0, 0);
      step(0, 0, 1, 13, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("er_bus", int'(io.bus), 33);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("keep_bus", int'(io.bus), 33);
      idle();
      chk("keep_a", int'(io.a_q), 33);
      step(0, 0, 1, 20, 1, 0, 0, 0);
      step(0, 0, 1, 30, 0, 1, 0, 0);
      step(0, 0, 1, 10, 1, 0, 1, 0);
      idle();
      chk("old_ab_r", int'(io.r_q), 50);
      chk("new_a", int'(io.a_q), 10);
      chk("old_ab_carry", int'(io.carry), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_a", int'(io.a_q), 0);
      chk("arst_b", int'(io.b_q), 0);
      chk("arst_r", int'(io.r_q), 0);
      chk("arst_bus", int'(io.bus), 0);
      chk("arst_zero", int'(io.zero), 1);
      chk("arst_err", int'(io.bus_err), 0);
      step(0, 0, 1, 9, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_ignores_strobes", int'(io.a_q), 0);
      rst_n = 1'b1;
      repeat (2) idle();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
